// File: rtl/issue_queue_param.sv
// Parametrised centralised issue queue.
// Dispatch writes up to DISP_W renamed instructions per cycle into the
// lowest free entries, wakeup broadcasts mark sources ready, and the oldest
// eligible entry is offered to execute through a valid/ready handshake.
module issue_queue_param #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 4,
  parameter int WK_W      = 2,
  parameter int OP_W      = 7,
  parameter int PRF_WIDTH = 6,
  parameter int AGE_W     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DISP_W-1:0]             disp_valid,
  output logic                          disp_ready,
  input  logic [DISP_W*OP_W-1:0]        disp_op,
  input  logic [DISP_W*PRF_WIDTH-1:0]   disp_prs1,
  input  logic [DISP_W*PRF_WIDTH-1:0]   disp_prs2,
  input  logic [DISP_W*PRF_WIDTH-1:0]   disp_prd,
  input  logic [DISP_W-1:0]             disp_prs1_v,
  input  logic [DISP_W-1:0]             disp_prs2_v,
  input  logic [DISP_W-1:0]             disp_prd_v,
  input  logic [DISP_W-1:0]             disp_prs1_rdy,
  input  logic [DISP_W-1:0]             disp_prs2_rdy,
  input  logic [WK_W-1:0]               wk_valid,
  input  logic [WK_W*PRF_WIDTH-1:0]     wk_tag,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [OP_W-1:0]               iss_op,
  output logic [PRF_WIDTH-1:0]          iss_prs1,
  output logic [PRF_WIDTH-1:0]          iss_prs2,
  output logic [PRF_WIDTH-1:0]          iss_prd,
  output logic                          iss_prs1_v,
  output logic                          iss_prs2_v,
  output logic                          iss_prd_v,
  output logic [$clog2(DEPTH)-1:0]      iss_idx,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic                 valid;
    logic [OP_W-1:0]      op;
    logic [PRF_WIDTH-1:0] prs1;
    logic [PRF_WIDTH-1:0] prs2;
    logic [PRF_WIDTH-1:0] prd;
    logic                 prs1_v;
    logic                 prs2_v;
    logic                 prd_v;
    logic                 rdy1;
    logic                 rdy2;
    logic [AGE_W-1:0]     age;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [OCC_W-1:0] occupancy_q;
  logic [OCC_W-1:0] occupancy_d;
  logic             disp_ready_q;
  logic             disp_ready_d;

  logic             sel_found_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [AGE_W-1:0] sel_age_s;
  logic             iss_fire_s;

  logic [DISP_W-1:0] lane_go_s;
  logic [IDX_W-1:0]  lane_slot_s [DISP_W];
  logic [DEPTH-1:0]  claimed_s;
  logic [OCC_W-1:0]  disp_cnt_s;

  // True when any valid broadcast port carries the given tag.
  function automatic logic wk_match(
    input logic [PRF_WIDTH-1:0]      tag,
    input logic [WK_W-1:0]           wv,
    input logic [WK_W*PRF_WIDTH-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WK_W; k++) begin
      hit = hit | (wv[k] & (wt[k*PRF_WIDTH +: PRF_WIDTH] == tag));
    end
    return hit;
  endfunction

  // An absent source never blocks; a present one needs its ready bit.
  function automatic logic eligible(input entry_t e);
    return e.valid & (~e.prs1_v | e.rdy1) & (~e.prs2_v | e.rdy2);
  endfunction

  // Oldest-eligible select over registered state; strict '>' keeps the lowest index on ties.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    sel_age_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible(ent_q[i]) && (!sel_found_s || (ent_q[i].age > sel_age_s))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        sel_age_s   = ent_q[i].age;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Drive the issue port from the selected entry, all-zero when nothing is eligible.
  always_comb begin
    if (sel_found_s) begin
      iss_valid  = 1'b1;
      iss_idx    = sel_idx_s;
      iss_op     = ent_q[sel_idx_s].op;
      iss_prs1   = ent_q[sel_idx_s].prs1;
      iss_prs2   = ent_q[sel_idx_s].prs2;
      iss_prd    = ent_q[sel_idx_s].prd;
      iss_prs1_v = ent_q[sel_idx_s].prs1_v;
      iss_prs2_v = ent_q[sel_idx_s].prs2_v;
      iss_prd_v  = ent_q[sel_idx_s].prd_v;
    end else begin
      iss_valid  = 1'b0;
      iss_idx    = '0;
      iss_op     = '0;
      iss_prs1   = '0;
      iss_prs2   = '0;
      iss_prd    = '0;
      iss_prs1_v = 1'b0;
      iss_prs2_v = 1'b0;
      iss_prd_v  = 1'b0;
    end
  end

  assign iss_fire_s = sel_found_s & iss_ready;
  assign disp_ready = disp_ready_q;
  assign occupancy  = occupancy_q;

  // Map active lanes, in lane order, onto the lowest free entries; an entry issuing
  // this cycle is still valid here, so it is only reusable next cycle.
  always_comb begin
    claimed_s  = '0;
    disp_cnt_s = '0;
    for (int l = 0; l < DISP_W; l++) begin
      lane_go_s[l]   = 1'b0;
      lane_slot_s[l] = '0;
      if (disp_ready_q && disp_valid[l]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (!lane_go_s[l] && !ent_q[e].valid && !claimed_s[e]) begin
            lane_go_s[l]   = 1'b1;
            lane_slot_s[l] = IDX_W'(e);
            claimed_s[e]   = 1'b1;
          end else begin
            lane_go_s[l] = lane_go_s[l];
          end
        end
        disp_cnt_s = disp_cnt_s + OCC_W'(lane_go_s[l]);
      end else begin
        lane_go_s[l] = 1'b0;
      end
    end
  end

  // Next entry state: wakeup, issue clear, age, dispatch write; flush overrides everything.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        ent_d[i].rdy1 = ent_q[i].rdy1 | wk_match(ent_q[i].prs1, wk_valid, wk_tag);
        ent_d[i].rdy2 = ent_q[i].rdy2 | wk_match(ent_q[i].prs2, wk_valid, wk_tag);
        if (iss_fire_s && (sel_idx_s == IDX_W'(i))) begin
          ent_d[i].valid = 1'b0;
          ent_d[i].age   = '0;
        end else if (ent_q[i].age != AGE_MAX) begin
          ent_d[i].age = ent_q[i].age + AGE_W'(1);
        end else begin
          ent_d[i].age = AGE_MAX;
        end
      end else begin
        ent_d[i].valid = 1'b0;
      end
    end

    for (int l = 0; l < DISP_W; l++) begin
      if (lane_go_s[l]) begin
        ent_d[lane_slot_s[l]].valid  = 1'b1;
        ent_d[lane_slot_s[l]].op     = disp_op[l*OP_W +: OP_W];
        ent_d[lane_slot_s[l]].prs1   = disp_prs1[l*PRF_WIDTH +: PRF_WIDTH];
        ent_d[lane_slot_s[l]].prs2   = disp_prs2[l*PRF_WIDTH +: PRF_WIDTH];
        ent_d[lane_slot_s[l]].prd    = disp_prd[l*PRF_WIDTH +: PRF_WIDTH];
        ent_d[lane_slot_s[l]].prs1_v = disp_prs1_v[l];
        ent_d[lane_slot_s[l]].prs2_v = disp_prs2_v[l];
        ent_d[lane_slot_s[l]].prd_v  = disp_prd_v[l];
        ent_d[lane_slot_s[l]].rdy1   = disp_prs1_rdy[l] |
          wk_match(disp_prs1[l*PRF_WIDTH +: PRF_WIDTH], wk_valid, wk_tag);
        ent_d[lane_slot_s[l]].rdy2   = disp_prs2_rdy[l] |
          wk_match(disp_prs2[l*PRF_WIDTH +: PRF_WIDTH], wk_valid, wk_tag);
        ent_d[lane_slot_s[l]].age    = '0;
      end else begin
        ent_d[lane_slot_s[l]] = ent_d[lane_slot_s[l]];
      end
    end

    occupancy_d = occupancy_q + disp_cnt_s - OCC_W'(iss_fire_s);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
      occupancy_d = '0;
    end else begin
      occupancy_d = occupancy_d;
    end

    disp_ready_d = ((OCC_W'(DEPTH) - occupancy_d) >= OCC_W'(DISP_W));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occupancy_q  <= '0;
      disp_ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      occupancy_q  <= occupancy_d;
      disp_ready_q <= disp_ready_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Self-checking bench for issue_queue_param: directed scenarios plus random
// traffic, all compared every cycle against a behavioural queue model.
module tb_issue_queue_param;

  localparam int DEPTH  = 16;
  localparam int DISP_W = 4;
  localparam int WK_W   = 2;
  localparam int OP_W   = 7;
  localparam int PW     = 6;
  localparam int AGE_W  = 5;
  localparam int AMAX   = (1 << AGE_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst, flush;
  logic [DISP_W-1:0]      disp_valid;
  logic                   disp_ready;
  logic [DISP_W*OP_W-1:0] disp_op;
  logic [DISP_W*PW-1:0]   disp_prs1, disp_prs2, disp_prd;
  logic [DISP_W-1:0]      disp_prs1_v, disp_prs2_v, disp_prd_v;
  logic [DISP_W-1:0]      disp_prs1_rdy, disp_prs2_rdy;
  logic [WK_W-1:0]        wk_valid;
  logic [WK_W*PW-1:0]     wk_tag;
  logic                   iss_valid, iss_ready;
  logic [OP_W-1:0]        iss_op;
  logic [PW-1:0]          iss_prs1, iss_prs2, iss_prd;
  logic                   iss_prs1_v, iss_prs2_v, iss_prd_v;
  logic [3:0]             iss_idx;
  logic [4:0]             occupancy;

  always #5 clk = ~clk;

  issue_queue_param #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .WK_W(WK_W),
    .OP_W(OP_W), .PRF_WIDTH(PW), .AGE_W(AGE_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2), .disp_prd(disp_prd),
    .disp_prs1_v(disp_prs1_v), .disp_prs2_v(disp_prs2_v), .disp_prd_v(disp_prd_v),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .wk_valid(wk_valid), .wk_tag(wk_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_prd(iss_prd),
    .iss_prs1_v(iss_prs1_v), .iss_prs2_v(iss_prs2_v), .iss_prd_v(iss_prd_v),
    .iss_idx(iss_idx), .occupancy(occupancy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit m_val [DEPTH];
  int m_op  [DEPTH];
  int m_s1  [DEPTH];
  int m_s2  [DEPTH];
  int m_d   [DEPTH];
  bit m_v1  [DEPTH];
  bit m_v2  [DEPTH];
  bit m_vd  [DEPTH];
  bit m_r1  [DEPTH];
  bit m_r2  [DEPTH];
  int m_age [DEPTH];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_val[i]) c++;
    return c;
  endfunction

  function automatic bit m_dr();
    return (DEPTH - m_count()) >= DISP_W;
  endfunction

  function automatic bit m_elig(int i);
    return m_val[i] && (!m_v1[i] || m_r1[i]) && (!m_v2[i] || m_r2[i]);
  endfunction

  // Oldest eligible entry, lowest index among equals; -1 if none.
  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_elig(i) && (best < 0 || m_age[i] > m_age[best])) best = i;
    return best;
  endfunction

  function automatic bit m_hit(int tag);
    for (int k = 0; k < WK_W; k++)
      if (wk_valid[k] && int'(wk_tag[k*PW +: PW]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] pk(int op, int s1, int s2, int d, bit v1, bit v2, bit vd);
    return 64'({OP_W'(op), PW'(s1), PW'(s2), PW'(d), v1, v2, vd});
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = 1'b0; m_age[i] = 0; m_op[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      m_d[i] = 0; m_v1[i] = 1'b0; m_v2[i] = 1'b0; m_vd[i] = 1'b0;
      m_r1[i] = 1'b0; m_r2[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_clock();
    int iss;
    int e;
    bit dr;
    bit was_free [DEPTH];
    if (rst || flush) begin
      m_clear();
      return;
    end
    iss = iss_ready ? m_pick() : -1;
    dr  = m_dr();
    for (int i = 0; i < DEPTH; i++) was_free[i] = !m_val[i];
    for (int i = 0; i < DEPTH; i++) begin
      if (m_val[i]) begin
        if (m_hit(m_s1[i])) m_r1[i] = 1'b1;
        if (m_hit(m_s2[i])) m_r2[i] = 1'b1;
        if (i == iss) m_val[i] = 1'b0;
        else if (m_age[i] < AMAX) m_age[i]++;
      end
    end
    if (dr) begin
      e = 0;
      for (int l = 0; l < DISP_W; l++) begin
        if (disp_valid[l]) begin
          while (e < DEPTH && !was_free[e]) e++;
          if (e < DEPTH) begin
            m_val[e] = 1'b1;
            m_op[e]  = int'(disp_op[l*OP_W +: OP_W]);
            m_s1[e]  = int'(disp_prs1[l*PW +: PW]);
            m_s2[e]  = int'(disp_prs2[l*PW +: PW]);
            m_d[e]   = int'(disp_prd[l*PW +: PW]);
            m_v1[e]  = disp_prs1_v[l];
            m_v2[e]  = disp_prs2_v[l];
            m_vd[e]  = disp_prd_v[l];
            m_r1[e]  = disp_prs1_rdy[l] || m_hit(m_s1[e]);
            m_r2[e]  = disp_prs2_rdy[l] || m_hit(m_s2[e]);
            m_age[e] = 0;
            e++;
          end
        end
      end
    end
  endtask

  task automatic m_compare();
    int p;
    logic [63:0] exp_f;
    p = m_pick();
    exp_f = (p >= 0) ? pk(m_op[p], m_s1[p], m_s2[p], m_d[p], m_v1[p], m_v2[p], m_vd[p])
                     : 64'd0;
    chk("iss_valid", 64'(iss_valid), 64'(p >= 0));
    chk("iss_idx", 64'(iss_idx), (p >= 0) ? 64'(p) : 64'd0);
    chk("iss_fields", pk(int'(iss_op), int'(iss_prs1), int'(iss_prs2), int'(iss_prd),
                         iss_prs1_v, iss_prs2_v, iss_prd_v), exp_f);
    chk("occupancy", 64'(occupancy), 64'(m_count()));
    chk("disp_ready", 64'(disp_ready), 64'(m_dr()));
  endtask

  // Compare at the falling edge, then clock both DUT and model.
  task automatic step();
    m_compare();
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_valid = '0; disp_op = '0;
    disp_prs1 = '0; disp_prs2 = '0; disp_prd = '0;
    disp_prs1_v = '0; disp_prs2_v = '0; disp_prd_v = '0;
    disp_prs1_rdy = '0; disp_prs2_rdy = '0;
    wk_valid = '0; wk_tag = '0; iss_ready = 1'b0;
  endtask

  task automatic set_lane(int l, int op, int s1, bit v1, bit r1, int s2, bit v2, bit r2, int d);
    disp_op[l*OP_W +: OP_W] = OP_W'(op);
    disp_prs1[l*PW +: PW]   = PW'(s1);
    disp_prs2[l*PW +: PW]   = PW'(s2);
    disp_prd[l*PW +: PW]    = PW'(d);
    disp_prs1_v[l] = v1; disp_prs1_rdy[l] = r1;
    disp_prs2_v[l] = v2; disp_prs2_rdy[l] = r2;
    disp_prd_v[l]  = 1'b1;
  endtask

  initial begin
    idle();
    m_clear();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    m_clock();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);

    // 1: four ready lanes issue in index order
    for (int l = 0; l < 4; l++) set_lane(l, l + 1, 0, 1, 1, 0, 1, 1, l + 8);
    disp_valid = 4'hF; iss_ready = 1'b1;
    step();
    disp_valid = '0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_idx", 64'(iss_idx), 64'(k));
      chk("t1_occ", 64'(occupancy), 64'(4 - k));
      step();
    end
    chk("t1_empty", 64'(occupancy), 64'd0);

    // 2: fill, back-pressure, wakeup of lane-0 entries
    iss_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      set_lane(0, 16 + g, 5, 1, 0, 0, 0, 0, 1);
      for (int l = 1; l < 4; l++) set_lane(l, 32 + g * 4 + l, 16, 1, 1, 0, 0, 0, 2);
      disp_valid = 4'hF;
      step();
    end
    chk("t2_full_ready", 64'(disp_ready), 64'd0);
    step();
    chk("t2_ignored", 64'(occupancy), 64'd16);
    disp_valid = '0;
    chk("t2_sel_pre", 64'(iss_idx), 64'd1);
    wk_valid = 2'b01; wk_tag = {6'h00, 6'h05};
    step();
    wk_valid = '0;
    chk("t2_sel_post", 64'(iss_idx), 64'd0);
    iss_ready = 1'b1;
    repeat (17) step();
    chk("t2_drained", 64'(occupancy), 64'd0);

    // 3: dispatch-cycle wakeup bypass
    set_lane(0, 51, 0, 0, 0, 42, 1, 0, 3);
    disp_valid = 4'b0001; wk_valid = 2'b10; wk_tag = {6'h2A, 6'h00};
    step();
    disp_valid = '0; wk_valid = '0;
    chk("t3_valid", 64'(iss_valid), 64'd1);
    chk("t3_prs2", 64'(iss_prs2), 64'h2A);
    step();
    chk("t3_empty", 64'(occupancy), 64'd0);

    // 4: old entry A beats young entry B at a lower index
    set_lane(0, 1, 18, 1, 0, 0, 0, 0, 4);
    set_lane(1, 74, 17, 1, 0, 0, 0, 0, 5);
    disp_valid = 4'b0011;
    step();
    disp_valid = '0;
    repeat (6) step();
    wk_valid = 2'b01; wk_tag = {6'h00, 6'h12};
    step();
    wk_valid = '0;
    chk("t4_filler", 64'(iss_idx), 64'd0);
    step();
    set_lane(0, 75, 0, 1, 1, 0, 1, 1, 6);
    disp_valid = 4'b0001; wk_valid = 2'b01; wk_tag = {6'h00, 6'h11};
    step();
    disp_valid = '0; wk_valid = '0;
    chk("t4_a_first", 64'(iss_idx), 64'd1);
    chk("t4_a_op", 64'(iss_op), 64'd74);
    step();
    chk("t4_b_next", 64'(iss_idx), 64'd0);
    step();
    chk("t4_empty", 64'(occupancy), 64'd0);

    // 5: non-contiguous lanes fill holes 1 and 3
    for (int l = 0; l < 4; l++) set_lane(l, 96 + l, 32 + l, 1, 0, 0, 0, 0, 7);
    disp_valid = 4'hF;
    step();
    disp_valid = '0;
    wk_valid = 2'b11; wk_tag = {6'h23, 6'h21};
    step();
    wk_valid = '0;
    chk("t5_i1", 64'(iss_idx), 64'd1);
    step();
    chk("t5_i3", 64'(iss_idx), 64'd3);
    step();
    chk("t5_occ2", 64'(occupancy), 64'd2);
    set_lane(1, 85, 49, 1, 0, 0, 0, 0, 8);
    set_lane(3, 102, 51, 1, 0, 0, 0, 0, 9);
    disp_valid = 4'b1010;
    step();
    disp_valid = '0;
    chk("t5_occ4", 64'(occupancy), 64'd4);
    wk_valid = 2'b01; wk_tag = {6'h00, 6'h31};
    step();
    wk_valid = '0;
    chk("t5_lane1_idx", 64'(iss_idx), 64'd1);
    chk("t5_lane1_op", 64'(iss_op), 64'h55);
    step();
    wk_valid = 2'b01; wk_tag = {6'h00, 6'h33};
    step();
    wk_valid = '0;
    chk("t5_lane3_idx", 64'(iss_idx), 64'd3);
    chk("t5_lane3_op", 64'(iss_op), 64'h66);
    step();

    // 6: flush, then rst, beat dispatch and issue
    wk_valid = 2'b01; wk_tag = {6'h00, 6'h20};
    step();
    wk_valid = '0;
    for (int l = 0; l < 4; l++) set_lane(l, 110 + l, 0, 1, 1, 0, 1, 1, 10);
    flush = 1'b1; disp_valid = 4'hF; iss_ready = 1'b1;
    step();
    flush = 1'b0; disp_valid = '0;
    chk("t6_f_occ", 64'(occupancy), 64'd0);
    chk("t6_f_valid", 64'(iss_valid), 64'd0);
    chk("t6_f_ready", 64'(disp_ready), 64'd1);
    step();
    chk("t6_f_nowrite", 64'(iss_valid), 64'd0);
    iss_ready = 1'b0; disp_valid = 4'hF;
    step();
    rst = 1'b1; iss_ready = 1'b1;
    step();
    rst = 1'b0; disp_valid = '0;
    chk("t6_r_occ", 64'(occupancy), 64'd0);
    chk("t6_r_valid", 64'(iss_valid), 64'd0);
    chk("t6_r_ready", 64'(disp_ready), 64'd1);
    step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      disp_valid = DISP_W'($urandom);
      for (int l = 0; l < DISP_W; l++)
        set_lane(l, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), 1'($urandom),
                 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 63)));
      wk_valid  = WK_W'($urandom_range(0, 3) & $urandom_range(0, 3));
      wk_tag    = {PW'($urandom_range(0, 15)), PW'($urandom_range(0, 15))};
      iss_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 149) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    iss_ready = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/issue_queue_param.md
Name: issue_queue_param

Overview:
Parametrised centralised issue queue, successor to the fixed 16-entry, 4-wide queue.
- Accepts up to DISP_W renamed instructions per cycle into free entries.
- Tracks source readiness through WK_W wakeup broadcast ports.
- Selects the oldest ready entry each cycle and issues it through a valid/ready handshake to the execution stage.
- Sits between rename/dispatch and register read/execute.

Parameters:
DEPTH, 16, number of queue entries (power of 2, ≥ DISP_W)
DISP_W, 4, dispatch lanes per cycle
WK_W, 2, wakeup broadcast ports
OP_W, 7, opcode width
PRF_WIDTH, 6, physical register tag width
AGE_W, 5, per-entry age counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries
disp_valid  in  DISP_W  per-lane dispatch valid; lane i uses bits/slices i
disp_ready  out  1  all-or-nothing accept for the whole dispatch group
disp_op  in  DISP_W*OP_W  opcodes
disp_prs1, disp_prs2, disp_prd  in  DISP_W*PRF_WIDTH  source/dest tags
disp_prs1_v, disp_prs2_v, disp_prd_v  in  DISP_W  operand-present flags
disp_prs1_rdy, disp_prs2_rdy  in  DISP_W  source already ready at dispatch
wk_valid  in  WK_W  wakeup broadcast valid
wk_tag  in  WK_W*PRF_WIDTH  woken physical register tags
iss_valid  out  1  an entry is selected
iss_ready  in  1  execution stage accepts
iss_op  out  OP_W  selected opcode
iss_prs1, iss_prs2, iss_prd  out  PRF_WIDTH  selected tags
iss_prs1_v, iss_prs2_v, iss_prd_v  out  1  selected operand flags
iss_idx  out  log2(DEPTH)  selected entry index
occupancy  out  log2(DEPTH)+1  count of valid entries

Behaviour:
- Entry state:
  - valid, op, prs1/prs2/prd, the three _v flags, rdy1, rdy2, age.
  - A source is satisfied when its _v is 0 or its rdy is 1.
  - An entry is eligible when valid and both sources are satisfied.
- Reset and flush: all valid=0, age=0, occupancy=0.
  - Outputs in the cycle after rst/flush: iss_valid=0, all iss_* fields 0, disp_ready=1.
  - Flush has priority over dispatch, wakeup and issue in the same cycle.
- disp_ready = (DEPTH − occupancy) ≥ DISP_W.
  - Computed from registered state only.
  - An entry freed by issue this cycle becomes available next cycle.
- Dispatch (disp_ready & any disp_valid):
  - Active lanes, in ascending lane order, are written to the lowest-index free entries in ascending order.
  - Inactive lanes consume no entry; lanes may be non-contiguous.
  - The written entry gets age=0.
  - rdy1 = disp_prs1_rdy OR a same-cycle wakeup match on prs1 (bypass); rdy2 likewise.
  - A newly written entry is eligible no earlier than the next cycle.
  - With disp_ready=0, disp_valid is ignored and nothing is written.
- Wakeup: for each valid entry and each port k, if wk_valid[k] and wk_tag[k]==prs1, set rdy1=1 (likewise rdy2).
  - Matching ignores the _v flags; setting rdy on an absent operand is harmless.
  - rdy bits never clear while the entry is valid.
- Select (combinational from registered state):
  - Chooses the eligible entry with the largest age; ties go to the lowest index.
  - iss_valid=1 iff any entry is eligible; iss_* carry that entry's fields.
  - When iss_valid=0, the iss_* fields are 0.
  - iss_valid/fields may change while iss_ready=0 (no hold requirement).
- Issue: on iss_valid & iss_ready, the selected entry's valid is cleared at the clock edge.
  - A wakeup arriving the same cycle does not make the selection include newly woken entries.
- Age: every valid entry not issued this cycle increments age by 1, saturating at 2^AGE_W−1.
- Occupancy: next = current + number of dispatched lanes − (1 if issued).
  - Must never exceed DEPTH or underflow.
  - Dispatch and issue in the same cycle are both applied.
- Throughput: 1 issue per cycle; DISP_W dispatches per cycle while disp_ready holds.

Test Plan:
1. Reset, then dispatch 4 lanes, all sources ready, iss_ready=1 → entries 0–3 filled.
   - Issue order is idx 0,1,2,3 over cycles 1–4 after the write (equal ages, lowest index wins).
   - occupancy goes 4,3,2,1,0.
2. Fill all 16 entries with lane 0 not ready (prs1=0x05, rdy1=0) and iss_ready=0 → disp_ready=0 when occupancy=16; further disp_valid is ignored.
   - Then pulse wk_tag=0x05: the matching entries become eligible the next cycle.
3. Dispatch prs2=0x2A with rdy2=0 in the same cycle as wk_valid[1]=1, wk_tag=0x2A → bypass sets rdy2; the entry issues the next cycle.
4. Entry A resident 6 cycles unready, entry B newly dispatched and ready; then wake A → A (larger age) issues before B despite B's lower index.
5. disp_valid=4'b1010 with entries 0 and 2 occupied → lane1 goes to entry 1, lane3 to entry 3; occupancy +2.
6. Flush asserted in the same cycle as dispatch and issue handshake → next cycle occupancy=0, iss_valid=0, disp_ready=1, no entry written; the same holds for rst asserted mid-operation.
